fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised successor to the dual-issue fetch unit. It fetches FETCH_W instructions per cycle from a fixed-latency instruction memory into a DEPTH-entry circular instruction queue and presents up to ISSUE_W in-order instructions per cycle to decode. It supports decode back-pressure (stall) and zero-bubble branch redirect with queue flush. It sits between instruction memory and the decode/rename stage.

## Interface
- DATA_W, 16, instruction width in bits
- ADDR_W, 16, PC width in bits; PC counts instructions, not bytes
- FETCH_W, 2, instructions returned per memory access
- ISSUE_W, 2, instruction slots presented to decode
- DEPTH, 8, queue entries; must be a power of 2, DEPTH >= 2*FETCH_W, ISSUE_W <= DEPTH
- RESET_PC, 0, PC after reset

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept; presented slots are not consumed
- is_branch_taken  in  1  redirect request, valid in the cycle it is asserted
- branch_target  in  ADDR_W  redirect PC
- imem_en  out  1  memory request this cycle (combinational)
- imem_addr  out  ADDR_W  request PC (combinational)
- imem_rdata  in  FETCH_W*DATA_W  instructions imem_addr+0..FETCH_W-1, slot 0 in LSBs, valid exactly one cycle after imem_en
- out_valid  out  ISSUE_W  thermometer valid, bit i = (occupancy > i)
- out_instr  out  ISSUE_W*DATA_W  queue head instructions, slot 0 in LSBs
- out_pc  out  ADDR_W  PC of slot 0; slot i PC = out_pc+i mod 2^ADDR_W
- occupancy  out  $clog2(DEPTH)+1  registered entry count

## Operation
- State: fetch_pc, head/tail pointers (mod DEPTH), count, head_pc, inflight flag (request issued last cycle).
- Queue contents are always PC-contiguous; the flush on branch guarantees this.
- Issue rule without a branch: imem_en = (count + (inflight ? FETCH_W : 0) + FETCH_W <= DEPTH). The check uses registered count and ignores same-cycle pops. imem_addr = fetch_pc. On issue, fetch_pc += FETCH_W.
- Issue rule with is_branch_taken=1: imem_en=1 and imem_addr=branch_target regardless of count. fetch_pc <= branch_target+FETCH_W. Queue is flushed (count, head, tail <= 0). head_pc <= branch_target. The response arriving this cycle is discarded. inflight <= 1.
- Response: when inflight=1 and no branch, write the FETCH_W instructions at tail, tail += FETCH_W, push = FETCH_W.
- Pop: pop = stall ? 0 : min(count, ISSUE_W). head += pop, head_pc += pop.
- count_next = count - pop + push. It never exceeds DEPTH by construction.
- Branch takes priority over stall, pop and push.
- All PC arithmetic wraps modulo 2^ADDR_W. Pointers wrap modulo DEPTH.
- Slots with out_valid=0 drive out_instr slot = 0.

## Timing
- Reset (async, while reset_n=0): fetch_pc=head_pc=RESET_PC, count=0, inflight=0. out_valid=0, occupancy=0, out_pc=RESET_PC, out_instr=0. imem_en=0 while reset_n low.
- First cycle after reset release: imem_en=1, imem_addr=RESET_PC.
- Latency is 2 cycles from request to out_valid. Request in cycle t, data written at end of t+1, visible on out_* in t+2.
- Free-running throughput is min(FETCH_W, ISSUE_W) per cycle sustained.
- Branch in cycle t: out_valid=0 in t+1; target instructions are valid in t+2 with out_pc=branch_target.
- Stall: out_* hold stable. Fetch continues until the issue rule blocks. There is no loss and no duplication.
- Full (count=DEPTH): imem_en=0 unless branch.
- Empty: out_valid=0, and stall is don't-care.
- reset_n asserted mid-operation: the in-flight response is dropped and all state clears immediately.

## Test plan
Defaults for all scenarios: DATA_W=16, ADDR_W=16, FETCH_W=2, ISSUE_W=2, DEPTH=8. The memory model returns A000+addr for every slot.

- Reset release, no stall -> imem_addr 0,2,4… each cycle. Two cycles later out_valid=11 with A000/A001 (out_pc=0), then A002/A003 (out_pc=2), continuing.
- stall=1 for 8 cycles mid-stream -> occupancy rises to 8 and holds. imem_en drops to 0 before overflow and outputs stay frozen. On release, slots resume with the exact next PCs, with no gap or repeat.
- is_branch_taken=1, branch_target=5 mid-stream -> imem_addr=5 that cycle and out_valid=00 next cycle. The cycle after: A005/A006, out_pc=5, then A007/A008.
- Branch with stall=1 and queue full -> same cycle imem_en=1 at the target, occupancy=0 next cycle, and the stale response is discarded.
- branch_target=FFFF -> slots FFFF then 0000 (A000+wrap), out_pc wraps to 0001 next.
- reset_n pulsed low for 3 ns mid-fetch -> out_valid=0 and occupancy=0 without waiting for a clock edge. Fetch restarts at RESET_PC, and the pre-reset response never appears.

Source files
------------

// File: rtl/fetch_queue_unit.sv
`timescale 1ns/1ps
// fetch_queue_unit: fetches FETCH_W instructions per cycle from a fixed
// one-cycle-latency instruction memory into a DEPTH-entry circular queue and
// presents up to ISSUE_W in-order instructions per cycle to decode.
//
// Decode handshake: out_valid[i] marks slot i as holding a real instruction
// (always thermometer coded). Decode consumes every valid slot in any cycle
// where stall=0; with stall=1 nothing is consumed and out_* hold. A taken
// branch overrides both: the queue is flushed and nothing is consumed.
module fetch_queue_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        stall,
    input  logic                        is_branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    output logic                        imem_en,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [FETCH_W*DATA_W-1:0]   imem_rdata,
    output logic [ISSUE_W-1:0]          out_valid,
    output logic [ISSUE_W*DATA_W-1:0]   out_instr,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0]       FETCH_SUM = (CW+1)'(FETCH_W);
    localparam logic [CW:0]       DEPTH_SUM = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     FETCH_CNT = CW'(FETCH_W);
    localparam logic [CW-1:0]     ISSUE_CNT = CW'(ISSUE_W);
    localparam logic [PW-1:0]     FETCH_PTR = PW'(FETCH_W);
    localparam logic [ADDR_W-1:0] FETCH_PC  = ADDR_W'(FETCH_W);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] head_pc;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic              inflight;

    logic [CW:0]       demand;
    logic [CW-1:0]     pop;
    logic [CW-1:0]     count_next;
    logic              push_en;

    logic [DATA_W-1:0] mem [DEPTH];

    // Request issue: reserve room for the in-flight response plus this one;
    // a branch always issues so the redirect costs no bubble.
    always_comb begin
        demand    = {1'b0, count} + (inflight ? FETCH_SUM : '0) + FETCH_SUM;
        imem_en   = reset_n && (is_branch_taken || (demand <= DEPTH_SUM));
        imem_addr = is_branch_taken ? branch_target : fetch_pc;
    end

    // Pop/push bookkeeping; a response landing in a branch cycle is stale.
    always_comb begin
        pop        = stall ? '0 : ((count < ISSUE_CNT) ? count : ISSUE_CNT);
        push_en    = inflight && !is_branch_taken;
        count_next = count - pop + (push_en ? FETCH_CNT : '0);
    end

    // Control state: pointers, count, PCs and the in-flight flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (is_branch_taken) begin
            fetch_pc <= branch_target + FETCH_PC;
            head_pc  <= branch_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b1;
        end else begin
            if (imem_en) begin
                fetch_pc <= fetch_pc + FETCH_PC;
            end
            if (push_en) begin
                tail <= tail + FETCH_PTR;
            end
            head     <= head + PW'(pop);
            head_pc  <= head_pc + ADDR_W'(pop);
            count    <= count_next;
            inflight <= imem_en;
        end
    end

    // Queue storage: write the whole fetch group at the tail.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int j = 0; j < FETCH_W; j++) begin
                mem[tail + PW'(j)] <= imem_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Head window presented to decode; invalid slots read as zero.
    always_comb begin
        out_valid = '0;
        out_instr = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            out_valid[i] = (count > CW'(i));
            if (out_valid[i]) begin
                out_instr[i*DATA_W +: DATA_W] = mem[head + PW'(i)];
            end
        end
        out_pc    = head_pc;
        occupancy = count;
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
`timescale 1ns/1ps
// Bench for fetch_queue_unit with a one-cycle memory returning A000+addr.
module tb_fetch_queue_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset_n = 1'b0;
  logic                       stall = 1'b0;
  logic                       is_branch_taken = 1'b0;
  logic [ADDR_W-1:0]          branch_target = '0;
  logic                       imem_en;
  logic [ADDR_W-1:0]          imem_addr;
  logic [FETCH_W*DATA_W-1:0]  imem_rdata = '0;
  logic [ISSUE_W-1:0]         out_valid;
  logic [ISSUE_W*DATA_W-1:0]  out_instr;
  logic [ADDR_W-1:0]          out_pc;
  logic [$clog2(DEPTH):0]     occupancy;

  fetch_queue_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FETCH_W(FETCH_W),
    .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .is_branch_taken(is_branch_taken), .branch_target(branch_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy)
  );

  // Instruction memory model: one-cycle latency, word = A000 + address.
  always @(posedge clk) begin
    if (imem_en) begin
      for (int j = 0; j < FETCH_W; j++) begin
        imem_rdata[j*DATA_W +: DATA_W] <= 16'hA000 + (imem_addr + 16'(j));
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected stream {pc, instr} starting at a given PC.
  task automatic sb_reload(input logic [15:0] pc);
    logic [15:0] p;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      p = pc + 16'(k);
      exp_q.push_back({p, 16'hA000 + p});
    end
  endtask

  // Compare slots decode consumes this cycle; idle slots must read zero.
  task automatic sb_check();
    logic [31:0] e;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (out_valid[i]) begin
        if (!stall && !is_branch_taken) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d", i), {out_pc + 16'(i), out_instr[i*DATA_W +: DATA_W]}, e);
          end
        end
      end else begin
        chk($sformatf("idle_slot%0d_zero", i), 32'(out_instr[i*DATA_W +: DATA_W]), 32'd0);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    @(negedge clk);
    stall           = s;
    is_branch_taken = b;
    branch_target   = t;
    #1;
    sb_check();
  endtask

  typedef struct {
    logic        stall;
    logic        en;
    logic [15:0] addr;
    logic [1:0]  valid;
    logic [3:0]  occ;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[15];

  task automatic set_vec(input int k, input logic s, input logic en, input logic [15:0] addr,
                         input logic [1:0] v, input logic [3:0] occ, input logic [15:0] pc);
    vecs[k].stall = s;
    vecs[k].en    = en;
    vecs[k].addr  = addr;
    vecs[k].valid = v;
    vecs[k].occ   = occ;
    vecs[k].pc    = pc;
  endtask

  // ---------------- test ----------------
  initial begin
    // Cycle-by-cycle from reset release: free run, 8-cycle stall, resume.
    set_vec(0,  0, 1, 16'd0,  2'b00, 4'd0, 16'd0);
    set_vec(1,  0, 1, 16'd2,  2'b00, 4'd0, 16'd0);
    set_vec(2,  0, 1, 16'd4,  2'b11, 4'd2, 16'd0);
    set_vec(3,  1, 1, 16'd6,  2'b11, 4'd2, 16'd2);
    set_vec(4,  1, 1, 16'd8,  2'b11, 4'd4, 16'd2);
    set_vec(5,  1, 0, 16'd0,  2'b11, 4'd6, 16'd2);
    for (int k = 6; k <= 10; k++) set_vec(k, 1, 0, 16'd0, 2'b11, 4'd8, 16'd2);
    set_vec(11, 0, 0, 16'd0,  2'b11, 4'd8, 16'd2);
    set_vec(12, 0, 1, 16'd10, 2'b11, 4'd6, 16'd4);
    set_vec(13, 0, 1, 16'd12, 2'b11, 4'd4, 16'd6);
    set_vec(14, 0, 1, 16'd14, 2'b11, 4'd4, 16'd8);

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);
    sb_reload(16'h0000);
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      step(vecs[k].stall, 1'b0, 16'h0);
      chk($sformatf("v%0d_en", k), 32'(imem_en), 32'(vecs[k].en));
      if (vecs[k].en) chk($sformatf("v%0d_addr", k), 32'(imem_addr), 32'(vecs[k].addr));
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].valid));
      chk($sformatf("v%0d_occ", k), 32'(occupancy), 32'(vecs[k].occ));
      chk($sformatf("v%0d_pc", k), 32'(out_pc), 32'(vecs[k].pc));
    end

    // Mid-stream branch to 5 with a response in flight.
    step(1'b0, 1'b1, 16'h0005);
    chk("br5_en", 32'(imem_en), 32'd1);
    chk("br5_addr", 32'(imem_addr), 32'h5);
    sb_reload(16'h0005);
    step(1'b0, 1'b0, 16'h0);
    chk("br5_bubble_valid", 32'(out_valid), 32'd0);
    chk("br5_bubble_occ", 32'(occupancy), 32'd0);
    step(1'b0, 1'b0, 16'h0);
    chk("br5_valid", 32'(out_valid), 32'd3);
    chk("br5_pc", 32'(out_pc), 32'h5);
    step(1'b0, 1'b0, 16'h0);
    chk("br5_pc_next", 32'(out_pc), 32'h7);

    // Fill the queue under stall, then branch while full and stalled.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'h0);
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_en", 32'(imem_en), 32'd0);
    step(1'b1, 1'b1, 16'h0020);
    chk("brfull_en", 32'(imem_en), 32'd1);
    chk("brfull_addr", 32'(imem_addr), 32'h20);
    sb_reload(16'h0020);
    step(1'b1, 1'b0, 16'h0);
    chk("brfull_occ", 32'(occupancy), 32'd0);
    chk("brfull_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 16'h0);
    chk("brfull_pc", 32'(out_pc), 32'h20);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Branch to FFFF: PC and instruction stream wrap.
    step(1'b0, 1'b1, 16'hFFFF);
    chk("brwrap_addr", 32'(imem_addr), 32'hFFFF);
    sb_reload(16'hFFFF);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    chk("wrap_pc", 32'(out_pc), 32'hFFFF);
    chk("wrap_slot1", 32'(out_instr[31:16]), 32'hA000);
    step(1'b0, 1'b0, 16'h0);
    chk("wrap_pc_next", 32'(out_pc), 32'h0001);
    step(1'b0, 1'b0, 16'h0);

    // 3 ns reset pulse between clock edges, with a fetch in flight.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_en", 32'(imem_en), 32'd0);
    chk("arst_pc", 32'(out_pc), 32'd0);
    #2 reset_n = 1'b1;
    #1;
    chk("arst_restart_en", 32'(imem_en), 32'd1);
    chk("arst_restart_addr", 32'(imem_addr), 32'd0);
    sb_reload(16'h0000);
    step(1'b0, 1'b0, 16'h0);
    chk("arst_c1_valid", 32'(out_valid), 32'd0);
    chk("arst_c1_addr", 32'(imem_addr), 32'd2);
    step(1'b0, 1'b0, 16'h0);
    chk("arst_c2_pc", 32'(out_pc), 32'd0);
    chk("arst_c2_valid", 32'(out_valid), 32'd3);

    // Random stall pattern: stream must stay gap-free and duplicate-free.
    for (int k = 0; k < 40; k++) step(1'($urandom_range(0, 1)), 1'b0, 16'h0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
